// File: rtl/vga_text_ctrl.sv
// ---------------------------------------------------------------------------
// vga_text_ctrl
//
// 80x30 text-mode VGA controller, 640x480 @ 60 Hz from a 25 MHz pixel clock.
// Characters are read from a 32x128 character buffer and expanded through an
// 8x16 font ROM. Both memories are external and read synchronously.
//
// Ports
//   clk          pixel clock (25 MHz)
//   reset_n      asynchronous reset, active-low
//   scroll_row   buffer row shown on screen row 0, taken at frame start
//   cursor_en    cursor enable
//   cursor_row   cursor screen row (0..29)
//   cursor_col   cursor screen column (0..79)
//   char_addr    character buffer address {buf_row, col}
//   char_data    character code, valid one cycle after char_addr
//   font_addr    font ROM address {char, glyph_row}
//   font_data    glyph row bits, valid one cycle after font_addr, bit 7 leftmost
//   vga_r/g/b    4-bit colour outputs
//   vga_hs/vs    sync outputs, active-low
//   frame_start  one-cycle pulse while the counters read (0,0)
// ---------------------------------------------------------------------------
module vga_text_ctrl #(
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter int          BLINK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  scroll_row,
    input  logic        cursor_en,
    input  logic [4:0]  cursor_row,
    input  logic [6:0]  cursor_col,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_VISIBLE  = 640;
    localparam int H_SYNC_BEG = 656;
    localparam int H_SYNC_END = 751;
    localparam int H_TOTAL    = 800;
    localparam int V_VISIBLE  = 480;
    localparam int V_SYNC_BEG = 490;
    localparam int V_SYNC_END = 491;
    localparam int V_TOTAL    = 525;

    // Per-pixel attributes carried alongside the memory fetches so that sync
    // and colour leave the block on the same cycle.
    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic       cur;
        logic [2:0] px;
    } pipe_t;

    localparam pipe_t PIPE_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0, px: 3'd0};

    // ---------------- raster counters, frame counter, scroll latch ----------
    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [5:0] frame_cnt, frame_nxt;
    logic [4:0] scroll_lat, scroll_nxt;
    logic       h_wrap, f_wrap;

    // NOTE: every variable gets a default at the top of the always_comb block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        h_wrap     = (h_cnt == 10'(H_TOTAL - 1));
        f_wrap     = h_wrap && (v_cnt == 10'(V_TOTAL - 1));
        h_nxt      = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt      = v_cnt;
        frame_nxt  = frame_cnt;
        scroll_nxt = scroll_lat;
        if (f_wrap) begin
            v_nxt      = 10'd0;
            frame_nxt  = frame_cnt + 6'd1;
            scroll_nxt = scroll_row;
        end else if (h_wrap) begin
            v_nxt = v_cnt + 10'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_cnt   <= '0;
            scroll_lat  <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            frame_cnt   <= frame_nxt;
            scroll_lat  <= scroll_nxt;
            frame_start <= f_wrap;   // counters read (0,0) on the next cycle
        end
    end

    // ---------------- stage 0: geometry and character fetch ----------------
    logic [6:0] col;
    logic [4:0] scr_row, buf_row;
    logic [3:0] glyph_row;
    pipe_t      s0;

    always_comb begin
        col       = h_cnt[9:3];
        scr_row   = v_cnt[8:4];
        glyph_row = v_cnt[3:0];
        buf_row   = scr_row + scroll_lat;   // 5-bit add wraps modulo 32
        char_addr = {buf_row, col};

        s0.vis = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
        s0.hs  = !((h_cnt >= 10'(H_SYNC_BEG)) && (h_cnt <= 10'(H_SYNC_END)));
        s0.vs  = !((v_cnt >= 10'(V_SYNC_BEG)) && (v_cnt <= 10'(V_SYNC_END)));
        s0.px  = h_cnt[2:0];
        // The cursor test is done here and carried along; frame_cnt only moves
        // during vertical blanking, so this matches evaluating it two stages on.
        s0.cur = cursor_en && (scr_row == cursor_row) && (col == cursor_col) &&
                 (glyph_row[3:1] == 3'b111) && !frame_cnt[BLINK_LOG2];
    end

    // ---------------- stage 1: font fetch ----------------------------------
    pipe_t      s1, s2;
    logic [3:0] glyph_d1;

    assign font_addr = {char_data, glyph_d1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= PIPE_RST;
            s2       <= PIPE_RST;
            glyph_d1 <= '0;
        end else begin
            s1       <= s0;
            s2       <= s1;
            glyph_d1 <= glyph_row;
        end
    end

    // ---------------- stage 2: pixel select, stage 3: output registers -----
    logic        pix_on;
    logic [11:0] rgb_nxt;

    always_comb begin
        pix_on  = font_data[3'd7 - s2.px] ^ s2.cur;
        rgb_nxt = 12'h000;
        if (s2.vis) begin
            rgb_nxt = pix_on ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            vga_hs                <= 1'b1;
            vga_vs                <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= rgb_nxt;
            vga_hs                <= s2.hs;
            vga_vs                <= s2.vs;
        end
    end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_text_ctrl
//
// Directed bench for vga_text_ctrl. Behavioural models stand in for the
// character buffer and font ROM. To stay within a short run, the bench jumps
// the vertical counter (and once the frame counter) forward with force/
// release between clock edges instead of simulating full 420000-cycle frames.
// All positions are tracked from the cycle count since reset release:
// after edge n the horizontal counter reads n mod 800.
// ---------------------------------------------------------------------------
module tb_vga_text_ctrl;

    localparam logic [11:0] FG = 12'hFA5;
    localparam logic [11:0] BG = 12'h03C;

    logic        clk;
    logic        reset_n;
    logic [4:0]  scroll_row;
    logic        cursor_en;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;
    logic        frame_start;

    vga_text_ctrl #(
        .FG_COLOR   (FG),
        .BG_COLOR   (BG),
        .BLINK_LOG2 (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scroll_row  (scroll_row),
        .cursor_en   (cursor_en),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .char_addr   (char_addr),
        .char_data   (char_data),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start)
    );

    // 25 MHz
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Synchronous-read memory models
    logic [7:0] char_mem [4096];
    logic [7:0] font_mem [4096];

    always @(posedge clk) begin
        char_data <= char_mem[char_addr];
        font_data <= font_mem[font_addr];
    end

    // Cycle count and time base
    int cyc  = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int h_now();
        return (cyc - base) % 800;
    endfunction

    // hsync edge monitor (timestamps relative to the last reset release)
    int   hs_falls[$];
    int   hs_rises[$];
    logic prev_hs = 1'b1;
    always @(negedge clk) begin
        if (prev_hs && !vga_hs) hs_falls.push_back(cyc - base);
        if (!prev_hs && vga_hs) hs_rises.push_back(cyc - base);
        prev_hs = vga_hs;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] rgb();
        return {vga_r, vga_g, vga_b};
    endfunction

    task automatic wait_rel(input int n);
        while (cyc - base < n) @(negedge clk);
    endtask

    // Always advances at least one cycle; lands on the next negedge with h==h_target.
    task automatic wait_h(input int h_target);
        do @(negedge clk); while (h_now() != h_target);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 1000);
        check({tag, "_seen"}, frame_start, 1'b1);
        check({tag, "_h0"}, h_now(), 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        scroll_row = 5'd0;
        cursor_en  = 1'b0;
        cursor_row = 5'd0;
        cursor_col = 7'd0;
        for (int i = 0; i < 4096; i++) begin
            char_mem[i] = 8'h00;
            font_mem[i] = 8'h00;
        end
        char_mem[0]      = 8'h41;
        font_mem[12'h410] = 8'b1000_0001;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_rgb", rgb(), 12'h000);
        check("rst_hs", vga_hs, 1'b1);
        check("rst_vs", vga_vs, 1'b1);
        check("rst_fs", frame_start, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;
        base    = cyc;
        hs_falls.delete();
        hs_rises.delete();

        // ---- line 0 pixel pipeline ----
        check("l0_rgb_rel0", rgb(), 12'h000);
        wait_rel(1);
        check("l0_font_addr", font_addr, 12'h410);
        check("l0_fs_low", frame_start, 1'b0);
        wait_rel(2);
        check("l0_rgb_early", rgb(), 12'h000);
        wait_rel(3);
        check("l0_px0", rgb(), FG);
        wait_rel(4);
        check("l0_px1", rgb(), BG);
        wait_rel(8);
        check("l0_char_addr_col1", char_addr, 12'h001);
        check("l0_px5", rgb(), BG);
        wait_rel(9);
        check("l0_px6", rgb(), BG);
        wait_rel(10);
        check("l0_px7", rgb(), FG);
        wait_rel(11);
        check("l0_px8", rgb(), BG);
        wait_rel(642);
        check("l0_px639", rgb(), BG);
        wait_rel(643);
        check("l0_px640_blank", rgb(), 12'h000);

        // ---- scroll change mid-frame (line 1) ----
        wait_rel(900);
        scroll_row = 5'd3;

        // ---- hsync timing ----
        wait_rel(1500);
        check("hs_fall_count", hs_falls.size(), 2);
        check("hs_first_fall", hs_falls[0], 659);
        check("hs_low_width", hs_rises[0] - hs_falls[0], 96);
        check("hs_period", hs_falls[1] - hs_falls[0], 800);

        // Same frame still shows buffer row 0
        wait_rel(1616);
        check("scroll_midframe", char_addr, 12'h002);

        // Jump to the last line; scroll_row is latched at the wrap
        wait_h(200); force dut.v_cnt = 10'd524; @(negedge clk); release dut.v_cnt;
        wait_frame("fs1");
        check("scroll3_row0", char_addr, 12'h180);
        @(negedge clk);
        check("fs1_pulse_end", frame_start, 1'b0);

        // ---- scroll_row = 31 ----
        scroll_row = 5'd31;
        wait_h(200); force dut.v_cnt = 10'd524; @(negedge clk); release dut.v_cnt;
        wait_frame("fs2");
        check("scroll31_row0", char_addr, 12'hF80);
        wait_h(200); force dut.v_cnt = 10'd15; @(negedge clk); release dut.v_cnt;
        wait_h(799);
        wait_h(0);
        check("scroll31_row1", char_addr, 12'h000);
        wait_h(3);
        check("scroll31_row1_px0", rgb(), FG);
        wait_h(4);
        check("scroll31_row1_px1", rgb(), BG);

        // ---- cursor at row 2, col 5 (frame_cnt = 2) ----
        cursor_en  = 1'b1;
        cursor_row = 5'd2;
        cursor_col = 7'd5;
        wait_h(200); force dut.v_cnt = 10'd44; @(negedge clk); release dut.v_cnt;
        wait_h(799);
        wait_h(43);
        check("cur_y45_x40", rgb(), BG);
        wait_h(799);
        wait_h(42);
        check("cur_y46_x39", rgb(), BG);
        wait_h(43);
        check("cur_y46_x40", rgb(), FG);
        wait_h(50);
        check("cur_y46_x47", rgb(), FG);
        wait_h(51);
        check("cur_y46_x48", rgb(), BG);
        wait_h(799);
        wait_h(47);
        check("cur_y47_x44", rgb(), FG);
        wait_h(799);
        wait_h(47);
        check("cur_y48_x44", rgb(), BG);

        // ---- vsync: low for lines 490..491, delayed 3 clocks ----
        wait_h(200); force dut.v_cnt = 10'd489; @(negedge clk); release dut.v_cnt;
        wait_h(799);
        wait_h(2);
        check("vs_before_fall", vga_vs, 1'b1);
        wait_h(3);
        check("vs_fall", vga_vs, 1'b0);
        wait_h(799);
        wait_h(799);
        check("vs_low_l491", vga_vs, 1'b0);
        wait_h(2);
        check("vs_before_rise", vga_vs, 1'b0);
        wait_h(3);
        check("vs_rise", vga_vs, 1'b1);

        // ---- blink off: frame_cnt 31 -> 32 ----
        wait_h(100); force dut.frame_cnt = 6'd31; @(negedge clk); release dut.frame_cnt;
        wait_h(200); force dut.v_cnt = 10'd524; @(negedge clk); release dut.v_cnt;
        wait_frame("fs3");
        wait_h(200); force dut.v_cnt = 10'd45; @(negedge clk); release dut.v_cnt;
        wait_h(799);
        wait_h(43);
        check("blink_off_y46_x40", rgb(), BG);

        // ---- frame_cnt wraps 63 -> 0: cursor visible again ----
        wait_h(100); force dut.frame_cnt = 6'd63; @(negedge clk); release dut.frame_cnt;
        wait_h(200); force dut.v_cnt = 10'd524; @(negedge clk); release dut.v_cnt;
        wait_frame("fs4");
        wait_h(200); force dut.v_cnt = 10'd45; @(negedge clk); release dut.v_cnt;
        wait_h(799);
        wait_h(43);
        check("blink_wrap_y46_x40", rgb(), FG);
        cursor_en = 1'b0;
        wait_h(799);
        wait_h(47);
        check("cursor_dis_y47_x44", rgb(), BG);

        // ---- asynchronous reset mid-line ----
        wait_h(799);
        wait_h(300);
        check("pre_reset_rgb", rgb(), BG);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rgb", rgb(), 12'h000);
        check("async_rst_hs", vga_hs, 1'b1);
        check("async_rst_vs", vga_vs, 1'b1);
        check("async_rst_fs", frame_start, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base    = cyc;
        hs_falls.delete();
        hs_rises.delete();

        // Counters and scroll latch restart from 0
        wait_rel(3);
        check("rerun_px0", rgb(), FG);
        wait_rel(8);
        check("rerun_char_addr", char_addr, 12'h001);
        wait_rel(1500);
        check("rerun_hs_fall_count", hs_falls.size(), 2);
        check("rerun_hs_first_fall", hs_falls[0], 659);
        check("rerun_hs_low_width", hs_rises[0] - hs_falls[0], 96);
        check("rerun_hs_period", hs_falls[1] - hs_falls[0], 800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
